mem_to_ring: RTL and testbench

//  Requester-side ring adapter: turns one core-side mem_if request into a ring READ/WRITE packet
//  for the memory stop, waits for the READ's ACK and returns the data to the core.

---
 rtl/mem_to_ring_pkg.sv | 28 ++
 rtl/mem_to_ring_ack_matcher.sv | 20 ++
 rtl/mem_to_ring.sv | 177 +++++++++++++++++
 tb/tb_mem_to_ring.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_to_ring_pkg.sv
// Shared ring definitions for the mem_to_ring requester adapter: packet layout,
// packet kinds, stop ID type and the data word returned on an aborted read.
package mem_to_ring_pkg;

  typedef logic [4:0] core_id_t;

  localparam logic [1:0] RING_PACKET_KIND_READ  = 2'd0;
  localparam logic [1:0] RING_PACKET_KIND_WRITE = 2'd1;
  localparam logic [1:0] RING_PACKET_KIND_ACK   = 2'd2;

  localparam logic [31:0] REQ_ABORT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        valid;
    logic [1:0]  kind;
    core_id_t    sender_id;
    logic [31:0] dest_vector;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic [3:0]  mem_data_en;
  } ring_packet;

  // One-hot destination mask for a single ring stop.
  function automatic logic [31:0] stop_mask(input core_id_t id);
    return 32'd1 << id;
  endfunction

endpackage

// File: rtl/mem_to_ring_ack_matcher.sv
// Combinational check that an inbound ring packet is the ACK answering the
// outstanding read of this stop.
module mem_to_ring_ack_matcher
  import mem_to_ring_pkg::*;
(
  input  logic        pkt_valid,
  input  logic [1:0]  pkt_kind,
  input  logic [31:0] pkt_dest_vector,
  input  logic [31:0] pkt_mem_address,
  input  core_id_t    core_id,
  input  logic [31:0] req_addr,
  output logic        match
);

  assign match = pkt_valid
              && (pkt_kind == RING_PACKET_KIND_ACK)
              && pkt_dest_vector[core_id]
              && (pkt_mem_address == req_addr);

endmodule

// File: rtl/mem_to_ring.sv
// Requester-side ring adapter: one core mem request becomes a READ/WRITE ring
// packet to the memory stop; reads wait for the matching ACK and return its data.
// Optional feature macro: RING_REQ_TIMEOUT_EN (WAIT_ACK timeout, re-injection
// and abort with timeout_err). Without it, WAIT_ACK waits indefinitely.
module mem_to_ring
  import mem_to_ring_pkg::*;
#(
  parameter int MEM_STOP_ID    = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] upper_mem_addr,
  input  logic        upper_mem_read_en,
  input  logic        upper_mem_write_en,
  input  logic [31:0] upper_mem_data_i,
  input  logic [3:0]  upper_mem_data_en,
  output logic [31:0] upper_mem_data_o,
  output logic        upper_mem_hit,
  output logic        upper_mem_done,
  output logic        injector_issue,
  output ring_packet  injector_packet,
  input  logic        injector_issuing,
  input  logic        receiver_issue,
  input  ring_packet  receiver_packet,
  output logic        receiver_ready,
  output logic        receiver_issuing,
  input  core_id_t    core_id,
  output logic [7:0]  stale_acks,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_INJECTING = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_RESPOND   = 2'd3;

  logic [1:0]  state;
  logic        pkt_valid;
  logic [1:0]  req_kind;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_en;
  logic        accept;
  logic        ack_match;
  logic        unused_rx;

  assign accept           = (state == ST_IDLE) && (upper_mem_read_en || upper_mem_write_en);
  assign receiver_ready   = ~receiver_issue;
  assign receiver_issuing = 1'b0;
  assign unused_rx        = ^{receiver_packet.sender_id, receiver_packet.mem_data_en};

  mem_to_ring_ack_matcher u_ack_matcher (
    .pkt_valid       (receiver_packet.valid),
    .pkt_kind        (receiver_packet.kind),
    .pkt_dest_vector (receiver_packet.dest_vector),
    .pkt_mem_address (receiver_packet.mem_address),
    .core_id         (core_id),
    .req_addr        (req_addr),
    .match           (ack_match)
  );

  // Outbound packet assembled from the request buffer; identical on every re-injection.
  always_comb begin
    injector_packet             = '0;
    injector_packet.valid       = pkt_valid;
    injector_packet.kind        = req_kind;
    injector_packet.sender_id   = core_id;
    injector_packet.dest_vector = stop_mask(core_id_t'(MEM_STOP_ID));
    injector_packet.mem_address = req_addr;
    injector_packet.mem_data    = req_data;
    injector_packet.mem_data_en = req_en;
  end

  // Request buffer: captured on accept only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_kind <= upper_mem_read_en ? RING_PACKET_KIND_READ : RING_PACKET_KIND_WRITE;
      req_addr <= upper_mem_addr;
      req_data <= upper_mem_data_i;
      req_en   <= upper_mem_data_en;
    end
  end

`ifdef RING_REQ_TIMEOUT_EN
  logic [15:0] timer;
  logic [7:0]  retries;
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT_CYCLES > 0) ^ (MAX_RETRIES > 0);
  assign timeout_err = 1'b0;
`endif

  // Request FSM, core handshake, injection control and stale-packet accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      upper_mem_hit    <= 1'b0;
      upper_mem_done   <= 1'b0;
      upper_mem_data_o <= '0;
      injector_issue   <= 1'b0;
      pkt_valid        <= 1'b0;
      stale_acks       <= '0;
`ifdef RING_REQ_TIMEOUT_EN
      timeout_err      <= 1'b0;
      timer            <= '0;
      retries          <= '0;
`endif
    end else begin
      upper_mem_hit  <= 1'b0;
      upper_mem_done <= 1'b0;
`ifdef RING_REQ_TIMEOUT_EN
      timeout_err    <= 1'b0;
`endif
      // Everything inbound except the awaited ACK is dropped and counted.
      if (receiver_issue && !((state == ST_WAIT_ACK) && ack_match) && (stale_acks != 8'hFF))
        stale_acks <= stale_acks + 8'd1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            upper_mem_hit  <= 1'b1;
            injector_issue <= 1'b1;
            pkt_valid      <= 1'b1;
            state          <= ST_INJECTING;
`ifdef RING_REQ_TIMEOUT_EN
            retries        <= '0;
`endif
          end
        end
        ST_INJECTING: begin
          if (injector_issuing) begin
            injector_issue <= 1'b0;
            pkt_valid      <= 1'b0;
            if (req_kind == RING_PACKET_KIND_WRITE) begin
              upper_mem_done <= 1'b1;
              state          <= ST_IDLE;
            end else begin
              state          <= ST_WAIT_ACK;
`ifdef RING_REQ_TIMEOUT_EN
              timer          <= '0;
`endif
            end
          end
        end
        ST_WAIT_ACK: begin
          if (receiver_issue && ack_match) begin
            upper_mem_data_o <= receiver_packet.mem_data;
            upper_mem_done   <= 1'b1;
            state            <= ST_RESPOND;
          end
`ifdef RING_REQ_TIMEOUT_EN
          else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
            if (retries == 8'(MAX_RETRIES)) begin
              upper_mem_data_o <= REQ_ABORT_DATA;
              upper_mem_done   <= 1'b1;
              timeout_err      <= 1'b1;
              state            <= ST_IDLE;
            end else begin
              retries          <= retries + 8'd1;
              injector_issue   <= 1'b1;
              pkt_valid        <= 1'b1;
              state            <= ST_INJECTING;
            end
          end else begin
            timer <= timer + 16'd1;
          end
`endif
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_to_ring.sv
// Directed bench for mem_to_ring: table of whole read/write transactions plus
// hand-written sequences for stale ACKs, stalled injection, reset mid-read,
// counter saturation and (with RING_REQ_TIMEOUT_EN) the retry/abort path.
module tb_mem_to_ring;
  import mem_to_ring_pkg::*;

  localparam logic [31:0] MEM_MASK = 32'h0000_0004;
  localparam logic [31:0] OWN_MASK = 32'h0000_0002;
  localparam core_id_t    OWN_ID   = 5'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] upper_mem_addr;
  logic        upper_mem_read_en;
  logic        upper_mem_write_en;
  logic [31:0] upper_mem_data_i;
  logic [3:0]  upper_mem_data_en;
  logic [31:0] upper_mem_data_o;
  logic        upper_mem_hit;
  logic        upper_mem_done;
  logic        injector_issue;
  ring_packet  injector_packet;
  logic        injector_issuing;
  logic        receiver_issue;
  ring_packet  receiver_packet;
  logic        receiver_ready;
  logic        receiver_issuing;
  core_id_t    core_id;
  logic [7:0]  stale_acks;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stale = 0;

  always #5 clk = ~clk;

  mem_to_ring #(.MEM_STOP_ID(2), .TIMEOUT_CYCLES(8), .MAX_RETRIES(3)) dut (
    .clk                (clk),
    .reset              (reset),
    .upper_mem_addr     (upper_mem_addr),
    .upper_mem_read_en  (upper_mem_read_en),
    .upper_mem_write_en (upper_mem_write_en),
    .upper_mem_data_i   (upper_mem_data_i),
    .upper_mem_data_en  (upper_mem_data_en),
    .upper_mem_data_o   (upper_mem_data_o),
    .upper_mem_hit      (upper_mem_hit),
    .upper_mem_done     (upper_mem_done),
    .injector_issue     (injector_issue),
    .injector_packet    (injector_packet),
    .injector_issuing   (injector_issuing),
    .receiver_issue     (receiver_issue),
    .receiver_packet    (receiver_packet),
    .receiver_ready     (receiver_ready),
    .receiver_issuing   (receiver_issuing),
    .core_id            (core_id),
    .stale_acks         (stale_acks),
    .timeout_err        (timeout_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  en;
    logic [31:0] ack_data;
    logic [1:0]  exp_kind;
    logic [31:0] exp_data_o;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bump_stale();
    if (exp_stale < 255) exp_stale++;
  endtask

  // One-cycle inbound packet; ready must drop while issue is high.
  task automatic send_pkt(input logic [1:0] kind, input logic [31:0] dest,
                          input logic [31:0] addr, input logic [31:0] data);
    receiver_issue              = 1'b1;
    receiver_packet             = '0;
    receiver_packet.valid       = 1'b1;
    receiver_packet.kind        = kind;
    receiver_packet.sender_id   = 5'd2;
    receiver_packet.dest_vector = dest;
    receiver_packet.mem_address = addr;
    receiver_packet.mem_data    = data;
    #1;
    chk("ready_low_on_issue", 64'(receiver_ready), 64'd0);
    tick();
    receiver_issue  = 1'b0;
    receiver_packet = '0;
  endtask

  // Present a request for one cycle; hit and the packet must appear next cycle.
  task automatic request(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] en, input logic [1:0] kind);
    upper_mem_read_en  = rd;
    upper_mem_write_en = wr;
    upper_mem_addr     = addr;
    upper_mem_data_i   = wdata;
    upper_mem_data_en  = en;
    tick();
    upper_mem_read_en  = 1'b0;
    upper_mem_write_en = 1'b0;
    chk("hit", 64'(upper_mem_hit), 64'd1);
    chk("issue", 64'(injector_issue), 64'd1);
    chk("pkt_valid", 64'(injector_packet.valid), 64'd1);
    chk("pkt_kind", 64'(injector_packet.kind), 64'(kind));
    chk("pkt_sender", 64'(injector_packet.sender_id), 64'(OWN_ID));
    chk("pkt_dest", 64'(injector_packet.dest_vector), 64'(MEM_MASK));
    chk("pkt_addr", 64'(injector_packet.mem_address), 64'(addr));
    chk("pkt_data", 64'(injector_packet.mem_data), 64'(wdata));
    chk("pkt_en", 64'(injector_packet.mem_data_en), 64'(en));
  endtask

  task automatic grant();
    injector_issuing = 1'b1;
    tick();
    injector_issuing = 1'b0;
    chk("issue_dropped", 64'(injector_issue), 64'd0);
    chk("valid_dropped", 64'(injector_packet.valid), 64'd0);
    chk("hit_one_cycle", 64'(upper_mem_hit), 64'd0);
  endtask

  task automatic finish_read(input logic [31:0] addr, input logic [31:0] data);
    send_pkt(RING_PACKET_KIND_ACK, OWN_MASK, addr, data);
    chk("read_done", 64'(upper_mem_done), 64'd1);
    chk("read_data", 64'(upper_mem_data_o), 64'(data));
    tick();
    chk("done_one_cycle", 64'(upper_mem_done), 64'd0);
    chk("data_held", 64'(upper_mem_data_o), 64'(data));
  endtask

  task automatic run_vec(input vec_t v);
    request(v.rd, v.wr, v.addr, v.wdata, v.en, v.exp_kind);
    grant();
    if (v.exp_kind == RING_PACKET_KIND_WRITE) begin
      chk("write_done", 64'(upper_mem_done), 64'd1);
      chk("write_data_o", 64'(upper_mem_data_o), 64'(v.exp_data_o));
      tick();
      chk("write_done_pulse", 64'(upper_mem_done), 64'd0);
    end else begin
      chk("no_done_after_issue", 64'(upper_mem_done), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("no_done_waiting", 64'(upper_mem_done), 64'd0);
      finish_read(v.addr, v.ack_data);
      chk("vec_data_o", 64'(upper_mem_data_o), 64'(v.exp_data_o));
    end
  endtask

  initial begin
    ring_packet exp_pkt;
    reset = 1'b1;
    upper_mem_addr = '0; upper_mem_read_en = 1'b0; upper_mem_write_en = 1'b0;
    upper_mem_data_i = '0; upper_mem_data_en = '0;
    injector_issuing = 1'b0; receiver_issue = 1'b0; receiver_packet = '0;
    core_id = OWN_ID;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hCAFE_F00D, RING_PACKET_KIND_READ,  32'hCAFE_F00D};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 32'h0, RING_PACKET_KIND_WRITE, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'h7777_0000, 4'h1, 32'h0BAD_F00D, RING_PACKET_KIND_READ, 32'h0BAD_F00D};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 4'h3, 32'h0, RING_PACKET_KIND_WRITE, 32'h0BAD_F00D};

    tick(); tick();
    chk("rst_hit", 64'(upper_mem_hit), 64'd0);
    chk("rst_done", 64'(upper_mem_done), 64'd0);
    chk("rst_data_o", 64'(upper_mem_data_o), 64'd0);
    chk("rst_issue", 64'(injector_issue), 64'd0);
    chk("rst_valid", 64'(injector_packet.valid), 64'd0);
    chk("rst_stale", 64'(stale_acks), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_ready", 64'(receiver_ready), 64'd1);
    chk("rx_issuing_tied", 64'(receiver_issuing), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    chk("no_stale_after_table", 64'(stale_acks), 64'(exp_stale));

    // Wrong-address and wrong-destination ACKs are discarded.
    request(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, RING_PACKET_KIND_READ);
    grant();
    send_pkt(RING_PACKET_KIND_ACK, OWN_MASK, 32'h0000_1004, 32'h1111_1111);
    bump_stale();
    send_pkt(RING_PACKET_KIND_ACK, MEM_MASK, 32'h0000_1000, 32'h2222_2222);
    bump_stale();
    chk("stale_two", 64'(stale_acks), 64'(exp_stale));
    chk("stale_no_done", 64'(upper_mem_done), 64'd0);
    finish_read(32'h0000_1000, 32'h55AA_33CC);

    // Injection stalled 10 cycles; a second request must not be accepted.
    request(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, RING_PACKET_KIND_READ);
    exp_pkt = '{1'b1, RING_PACKET_KIND_READ, OWN_ID, MEM_MASK, 32'h0000_3000, 32'h0, 4'h0};
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        upper_mem_write_en = 1'b1;
        upper_mem_addr     = 32'h0000_5000;
      end
      chk("stall_issue", 64'(injector_issue), 64'd1);
      n_checks++;
      if (injector_packet !== exp_pkt) begin
        n_fail++;
        $display("FAIL stall_packet: got %h, expected %h", injector_packet, exp_pkt);
      end
      tick();
      chk("stall_no_hit", 64'(upper_mem_hit), 64'd0);
    end
    upper_mem_write_en = 1'b0;
    // Grant and a stray inbound packet in the same cycle.
    injector_issuing            = 1'b1;
    receiver_issue              = 1'b1;
    receiver_packet             = '0;
    receiver_packet.valid       = 1'b1;
    receiver_packet.kind        = RING_PACKET_KIND_ACK;
    receiver_packet.dest_vector = OWN_MASK;
    receiver_packet.mem_address = 32'h0000_9999;
    tick();
    injector_issuing = 1'b0;
    receiver_issue   = 1'b0;
    receiver_packet  = '0;
    bump_stale();
    chk("simul_issue_drop", 64'(injector_issue), 64'd0);
    chk("simul_stale", 64'(stale_acks), 64'(exp_stale));
    finish_read(32'h0000_3000, 32'h0F0F_F0F0);
    chk("second_req_ignored", 64'(upper_mem_hit), 64'd0);

    // Reset during WAIT_ACK; the late ACK is stale.
    request(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0, RING_PACKET_KIND_READ);
    grant();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_stale = 0;
    chk("midrst_done", 64'(upper_mem_done), 64'd0);
    chk("midrst_issue", 64'(injector_issue), 64'd0);
    chk("midrst_stale", 64'(stale_acks), 64'd0);
    send_pkt(RING_PACKET_KIND_ACK, OWN_MASK, 32'h0000_6000, 32'h6666_6666);
    bump_stale();
    chk("late_ack_no_done", 64'(upper_mem_done), 64'd0);
    chk("late_ack_stale", 64'(stale_acks), 64'(exp_stale));
    chk("late_ack_data_o", 64'(upper_mem_data_o), 64'd0);
    tick();
    chk("late_ack_no_done2", 64'(upper_mem_done), 64'd0);
    run_vec('{1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 32'h7070_7070, RING_PACKET_KIND_READ, 32'h7070_7070});

    // Saturation of the stale counter.
    for (int i = 0; i < 256; i++) begin
      receiver_issue              = 1'b1;
      receiver_packet             = '0;
      receiver_packet.valid       = 1'b1;
      receiver_packet.kind        = RING_PACKET_KIND_ACK;
      receiver_packet.dest_vector = OWN_MASK;
      tick();
      bump_stale();
    end
    receiver_issue  = 1'b0;
    receiver_packet = '0;
    chk("stale_saturated", 64'(stale_acks), 64'd255);
    chk("stale_model", 64'(stale_acks), 64'(exp_stale));

`ifdef RING_REQ_TIMEOUT_EN
    begin
      int  reissues;
      logic got_done;
      reissues = 0;
      got_done = 1'b0;
      request(1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'h0, RING_PACKET_KIND_READ);
      grant();
      for (int c = 0; c < 200 && !got_done; c++) begin
        if (injector_issue) begin
          chk("reissue_addr", 64'(injector_packet.mem_address), 64'h8000);
          chk("reissue_valid", 64'(injector_packet.valid), 64'd1);
          reissues++;
          injector_issuing = 1'b1;
          tick();
          injector_issuing = 1'b0;
        end else begin
          tick();
        end
        if (upper_mem_done) got_done = 1'b1;
      end
      chk("timeout_done_seen", 64'(got_done), 64'd1);
      chk("timeout_reissues", 64'(reissues), 64'd3);
      chk("timeout_err", 64'(timeout_err), 64'd1);
      chk("timeout_data", 64'(upper_mem_data_o), 64'hDEAD_BEEF);
      tick();
      chk("timeout_err_pulse", 64'(timeout_err), 64'd0);
      chk("timeout_done_pulse", 64'(upper_mem_done), 64'd0);
    end
`else
    chk("timeout_err_tied", 64'(timeout_err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
